int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 The module SHALL have parameter NUM_IRQ, default 4, giving the number of interrupt sources; bit 0 is highest priority.
REQ-002 The module SHALL have parameter VEC_WIDTH, default 16, giving the vector width (matches PMA_SIZE).
REQ-003 The module SHALL have parameter VEC_BASE, default 16'h0008, giving the vector of source 0.
REQ-004 The module SHALL have parameter VEC_STRIDE, default 4, giving the vector spacing between consecutive sources.
REQ-005 Port: clk, input, 1, clock; all state changes on its rising edge.
REQ-006 Port: reset, input, 1, reset; asynchronous, active-low.
REQ-007 Port: irq_in, input, NUM_IRQ, interrupt request lines; rising-edge sensitive, synchronous to clk.
REQ-008 Port: imask_wr, input, 1, write strobe for the mask register.
REQ-009 Port: imask_wdata, input, NUM_IRQ, mask write data; 1 = enabled.
REQ-010 Port: gie, input, 1, global interrupt enable from the sequencer.
REQ-011 Port: ps_idle, input, 1, sequencer is in IDLE.
REQ-012 Port: stallb, input, 1, active-low pipeline stall; int_ack and rti are ignored while stallb=0.
REQ-013 Port: int_ack, input, 1, sequencer accepts the presented vector.
REQ-014 Port: rti, input, 1, return-from-interrupt executed.
REQ-015 Port: int_req, output, 1, interrupt request to the sequencer.
REQ-016 Port: int_vec, output, VEC_WIDTH, vector address of the requested source.
REQ-017 Port: ilat, output, NUM_IRQ, latched pending bits.
REQ-018 Port: imask, output, NUM_IRQ, current mask register.
REQ-019 Port: insvc, output, NUM_IRQ, in-service bitmap (nesting state).
REQ-020 Port: wake, output, 1, registered wake pulse to release the sequencer from IDLE.

Function
REQ-021 irq_in SHALL be registered once, and a 0->1 transition (irq_in & ~irq_d) SHALL set the matching ilat bit at that clock edge.
REQ-022 Eligible set SHALL be ilat & imask & ~prio_block, where prio_block has a 1 at every bit position >= the lowest-index set insvc bit; eligible is all-zero when gie=0.
REQ-023 The selected source SHALL be the lowest-index eligible bit, and its vector SHALL be VEC_BASE + index*VEC_STRIDE, truncated to VEC_WIDTH.
REQ-024 The FSM SHALL have 2 states: IDLE and REQ.
REQ-025 In IDLE with a non-empty eligible set, the FSM SHALL register int_req=1 and int_vec, latch the selected index, and enter REQ; int_req is therefore asserted one cycle after the ilat bit sets.
REQ-026 In REQ, int_req and int_vec SHALL hold stable until int_ack=1 with stallb=1, even if a higher-priority source becomes eligible (no vector swap mid-handshake).
REQ-027 On acceptance, the module SHALL clear ilat[idx], set insvc[idx], drive int_req=0 on the next cycle, and return to IDLE.
REQ-028 In REQ, if gie drops or imask[idx] is cleared before acceptance, the module SHALL withdraw the request (int_req=0 next cycle, return to IDLE) and leave ilat[idx] set.
REQ-029 rti with stallb=1 SHALL clear the lowest-index set insvc bit; rti with insvc all-zero SHALL have no effect.
REQ-030 An edge on irq_in[k] in the same cycle that ilat[k] is cleared by acceptance SHALL leave ilat[k]=1 (new event wins).
REQ-031 rti and acceptance in the same cycle SHALL both apply: the old lowest insvc bit is cleared and the new bit is set.
REQ-032 imask_wr SHALL update imask at the clock edge, and eligibility SHALL use the new mask from the following cycle.
REQ-033 int_ack in IDLE SHALL be ignored.
REQ-034 wake SHALL be a one-cycle pulse registered when ps_idle=1 and (ilat & imask) becomes non-zero (rising of that condition); wake is independent of gie.
REQ-035 A repeated edge on an already-set ilat bit SHALL be lost (no counting).

Reset
REQ-036 On reset=0, asynchronously: ilat=0, imask=0, insvc=0, irq_d=0, int_req=0, int_vec=0, wake=0, FSM=IDLE.
REQ-037 Reset asserted mid-handshake SHALL drop int_req immediately, and after release no request SHALL be issued until a new irq_in edge arrives.

Verification
REQ-038 imask=4'hF, gie=1, pulse irq_in[2] -> ilat=4'b0100 next edge, int_req=1 and int_vec=16'h0010 one cycle later; int_ack -> ilat=0, insvc=4'b0100, int_req=0.
REQ-039 insvc=4'b0100, edges on irq_in[3] and irq_in[1] together -> request for source 1 only (vec 16'h000C), source 3 stays in ilat; rti twice -> insvc=0, then source 3 is requested.
REQ-040 int_req held for 5 cycles with stallb=0 and int_ack=1 -> no acceptance; stallb=1 -> accepted on that edge.
REQ-041 Pending source, then imask_wr with 0 while in REQ -> int_req drops next cycle, ilat bit stays 1; re-enable -> request reissued.
REQ-042 ps_idle=1, gie=0, imask=4'h1, irq_in[0] edge -> wake pulses for exactly 1 cycle, int_req stays 0.
REQ-043 Reset pulse while int_req=1 -> all outputs 0 immediately; irq_in held high across release -> no new ilat bit set.

Source files
------------

// File: rtl/int_ctrl.sv
// Prioritised, nesting interrupt controller: latches irq_in rising edges, masks them,
// and runs a request/acknowledge handshake with the sequencer while tracking in-service nesting.
module int_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter int          VEC_WIDTH  = 16,
  parameter int unsigned VEC_BASE   = 32'h0008,
  parameter int unsigned VEC_STRIDE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IRQ-1:0]   irq_in,
  input  logic                 imask_wr,
  input  logic [NUM_IRQ-1:0]   imask_wdata,
  input  logic                 gie,
  input  logic                 ps_idle,
  input  logic                 stallb,
  input  logic                 int_ack,
  input  logic                 rti,
  output logic                 int_req,
  output logic [VEC_WIDTH-1:0] int_vec,
  output logic [NUM_IRQ-1:0]   ilat,
  output logic [NUM_IRQ-1:0]   imask,
  output logic [NUM_IRQ-1:0]   insvc,
  output logic                 wake
);
  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t               state_q, state_d;
  logic [NUM_IRQ-1:0]   irq_d_q;
  logic [NUM_IRQ-1:0]   ilat_q, ilat_d;
  logic [NUM_IRQ-1:0]   imask_q, imask_d;
  logic [NUM_IRQ-1:0]   insvc_q, insvc_d;
  logic [IDX_W-1:0]     idx_q, idx_d, sel_idx;
  logic [VEC_WIDTH-1:0] int_vec_q, int_vec_d;
  logic                 int_req_q, int_req_d;
  logic                 wake_q, wake_d;
  logic                 cond_q;
  logic                 arm_q;
  logic [NUM_IRQ-1:0]   irq_edge, prio_block, eligible;
  logic                 accept, cond;

  // arm_q masks the first sample after reset, so a line held high across release is not an edge.
  assign irq_edge = irq_in & ~irq_d_q & {NUM_IRQ{arm_q}};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_block
      assign prio_block[gi] = |insvc_q[gi:0];
    end
  endgenerate

  assign eligible = ilat_q & imask_q & ~prio_block & {NUM_IRQ{gie}};
  assign accept   = (state_q == S_REQ) & int_ack & stallb;
  assign cond     = |(ilat_q & imask_q);
  assign wake_d   = ps_idle & cond & ~cond_q;

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    int_req_d = int_req_q;
    int_vec_d = int_vec_q;
    idx_d     = idx_q;
    unique case (state_q)
      S_IDLE: begin
        int_req_d = 1'b0;
        if (|eligible) begin
          state_d   = S_REQ;
          int_req_d = 1'b1;
          idx_d     = sel_idx;
          int_vec_d = VEC_WIDTH'(VEC_BASE) + VEC_WIDTH'(sel_idx) * VEC_WIDTH'(VEC_STRIDE);
        end
      end
      S_REQ: begin
        // Vector stays frozen until accepted or withdrawn; no mid-handshake swap.
        if (accept || !gie || !imask_q[idx_q]) begin
          state_d   = S_IDLE;
          int_req_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ilat_d  = ilat_q;
    insvc_d = insvc_q;
    imask_d = imask_wr ? imask_wdata : imask_q;
    if (rti && stallb) insvc_d = insvc_q & (insvc_q - NUM_IRQ'(1));
    if (accept) begin
      ilat_d[idx_q]  = 1'b0;
      insvc_d[idx_q] = 1'b1;
    end
    ilat_d = ilat_d | irq_edge;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      irq_d_q   <= '0;
      ilat_q    <= '0;
      imask_q   <= '0;
      insvc_q   <= '0;
      idx_q     <= '0;
      int_vec_q <= '0;
      int_req_q <= 1'b0;
      wake_q    <= 1'b0;
      cond_q    <= 1'b0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      irq_d_q   <= irq_in;
      ilat_q    <= ilat_d;
      imask_q   <= imask_d;
      insvc_q   <= insvc_d;
      idx_q     <= idx_d;
      int_vec_q <= int_vec_d;
      int_req_q <= int_req_d;
      wake_q    <= wake_d;
      cond_q    <= cond;
      arm_q     <= 1'b1;
    end
  end

  assign int_req = int_req_q;
  assign int_vec = int_vec_q;
  assign ilat    = ilat_q;
  assign imask   = imask_q;
  assign insvc   = insvc_q;
  assign wake    = wake_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus randomized traffic, all checked against a
// cycle-level behavioural model of pending/mask/in-service bookkeeping.
module tb_int_ctrl;
  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [NI-1:0] irq_in, imask_wdata;
  logic        imask_wr, gie, ps_idle, stallb, int_ack, rti;
  logic        int_req, wake;
  logic [15:0] int_vec;
  logic [NI-1:0] ilat, imask, insvc;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [NI-1:0] m_ilat, m_mask, m_svc, m_prev;
  bit  m_armed, m_busy, m_req, m_wake, m_pcond;
  int  m_idx, m_vec;

  int_ctrl #(.NUM_IRQ(NI), .VEC_WIDTH(16), .VEC_BASE(32'h0008), .VEC_STRIDE(4)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .imask_wr(imask_wr),
    .imask_wdata(imask_wdata), .gie(gie), .ps_idle(ps_idle), .stallb(stallb),
    .int_ack(int_ack), .rti(rti), .int_req(int_req), .int_vec(int_vec),
    .ilat(ilat), .imask(imask), .insvc(insvc), .wake(wake)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ilat = '0; m_mask = '0; m_svc = '0; m_prev = '0;
    m_armed = 0; m_busy = 0; m_req = 0; m_wake = 0; m_pcond = 0;
    m_idx = 0; m_vec = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [NI-1:0] n_ilat, n_svc;
    int lo, cand;
    bit acc, wdr, cnd;
    lo = NI;
    for (int k = NI - 1; k >= 0; k--) if (m_svc[k]) lo = k;
    cand = -1;
    if (gie) for (int k = lo - 1; k >= 0; k--) if (m_ilat[k] && m_mask[k]) cand = k;
    acc = m_busy && stallb && int_ack;
    wdr = m_busy && !acc && (!gie || !m_mask[m_idx]);
    cnd = 0;
    for (int k = 0; k < NI; k++) if (m_ilat[k] && m_mask[k]) cnd = 1;
    n_ilat = m_ilat;
    n_svc  = m_svc;
    if (rti && stallb && lo < NI) n_svc[lo] = 1'b0;
    if (acc) begin
      n_ilat[m_idx] = 1'b0;
      n_svc[m_idx]  = 1'b1;
      $display("ack   src=%0d vec=%04h t=%0t", m_idx, m_vec, $time);
    end
    for (int k = 0; k < NI; k++) begin
      if (m_armed && irq_in[k] && !m_prev[k]) n_ilat[k] = 1'b1;
      m_prev[k] = irq_in[k];
      if (imask_wr) m_mask[k] = imask_wdata[k];
    end
    m_wake  = ps_idle && cnd && !m_pcond;
    m_pcond = cnd;
    if (m_busy) begin
      if (acc || wdr) m_busy = 0;
    end else if (cand >= 0) begin
      m_busy = 1;
      m_idx  = cand;
      m_vec  = (8 + cand * 4) & 16'hFFFF;
    end
    m_req   = m_busy;
    m_ilat  = n_ilat;
    m_svc   = n_svc;
    m_armed = 1;
  endtask

  task automatic compare_all();
    check("int_req", int_req, m_req);
    if (m_req) check("int_vec", int_vec, m_vec);
    check("ilat", ilat, m_ilat);
    check("imask", imask, m_mask);
    check("insvc", insvc, m_svc);
    check("wake", wake, m_wake);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b0; irq_in = '0; imask_wr = 0; imask_wdata = '0; gie = 0;
    ps_idle = 0; stallb = 1; int_ack = 0; rti = 0;
    model_reset();
    #12;
    check("rst_req", int_req, 0); check("rst_vec", int_vec, 0);
    check("rst_ilat", ilat, 0);   check("rst_imask", imask, 0);
    check("rst_insvc", insvc, 0); check("rst_wake", wake, 0);
    @(negedge clk); reset = 1'b1;

    // Single source through a full handshake
    imask_wr = 1; imask_wdata = 4'hF; gie = 1; tick();
    imask_wr = 0; irq_in = 4'b0100; tick();
    check("t38_ilat", ilat, 4'b0100); check("t38_req0", int_req, 0);
    irq_in = 0; tick();
    check("t38_req", int_req, 1); check("t38_vec", int_vec, 16'h0010);
    int_ack = 1; tick(); int_ack = 0;
    check("t38_ilat_clr", ilat, 0); check("t38_insvc", insvc, 4'b0100);
    check("t38_req_drop", int_req, 0);

    // Nesting: higher priority preempts, lower stays pending until rti unwinds
    irq_in = 4'b1010; tick();
    irq_in = 0; tick();
    check("t39_req", int_req, 1); check("t39_vec", int_vec, 16'h000C);
    int_ack = 1; tick(); int_ack = 0;
    check("t39_insvc", insvc, 4'b0110); check("t39_ilat", ilat, 4'b1000);
    tick(); check("t39_blocked", int_req, 0);
    rti = 1; tick(); check("t39_rti1", insvc, 4'b0100);
    tick(); check("t39_rti2", insvc, 0);
    rti = 0; tick();
    check("t39_req3", int_req, 1); check("t39_vec3", int_vec, 16'h0014);

    // Stall blocks acceptance
    stallb = 0; int_ack = 1;
    for (int i = 0; i < 5; i++) begin
      tick(); check("t40_hold", int_req, 1); check("t40_svc", insvc, 0);
    end
    stallb = 1; tick(); int_ack = 0;
    check("t40_acc_req", int_req, 0); check("t40_acc_svc", insvc, 4'b1000);
    rti = 1; tick(); rti = 0;

    // Mask cleared mid-handshake withdraws; re-enable reissues
    irq_in = 4'b0001; tick();
    irq_in = 0; tick();
    check("t41_req", int_req, 1); check("t41_vec", int_vec, 16'h0008);
    imask_wr = 1; imask_wdata = 0; tick(); imask_wr = 0;
    tick(); check("t41_drop", int_req, 0); check("t41_ilat", ilat, 4'b0001);
    imask_wr = 1; imask_wdata = 4'hF; tick(); imask_wr = 0;
    tick(); check("t41_reissue", int_req, 1);
    int_ack = 1; tick(); int_ack = 0;
    rti = 1; tick(); rti = 0;

    // Wake independent of gie
    gie = 0; ps_idle = 1; imask_wr = 1; imask_wdata = 4'h1; tick(); imask_wr = 0;
    irq_in = 4'b0001; tick();
    irq_in = 0; tick();
    check("t42_wake", wake, 1); check("t42_noreq", int_req, 0);
    tick(); check("t42_wake_off", wake, 0);
    tick(); check("t42_wake_off2", wake, 0);

    // Reset mid-handshake, irq held high across release
    gie = 1; ps_idle = 0; tick();
    check("t43_req", int_req, 1);
    irq_in = 4'hF;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("t43_req0", int_req, 0); check("t43_ilat0", ilat, 0);
    check("t43_imask0", imask, 0); check("t43_insvc0", insvc, 0);
    check("t43_vec0", int_vec, 0); check("t43_wake0", wake, 0);
    @(negedge clk); reset = 1'b1;
    tick(); check("t43_noedge", ilat, 0);
    tick(); check("t43_noedge2", ilat, 0); check("t43_noreq", int_req, 0);
    irq_in = 0; tick();
    irq_in = 4'b0001; tick(); check("t43_newedge", ilat, 4'b0001);

    // Randomized traffic
    irq_in = 0; imask_wr = 1; imask_wdata = 4'hF; tick();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NI; k++) if ($urandom_range(5) == 0) irq_in[k] = ~irq_in[k];
      imask_wr    = ($urandom_range(15) == 0);
      imask_wdata = NI'($urandom);
      gie         = ($urandom_range(15) != 0);
      stallb      = ($urandom_range(3) != 0);
      int_ack     = m_req ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      rti         = ($urandom_range(9) == 0);
      ps_idle     = 1'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
